fpu_unit: RTL and testbench



---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_round.sv | 41 ++++
 rtl/fpu_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_fpu_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision FPU coprocessor.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {ADD, SUB, MUL, DIV} op_e;
  typedef enum logic [1:0] {RNE, RTZ, RUP, RDN} rnd_e;
  typedef enum logic [2:0] {IDLE, UNPACK, CALC, NORM, ROUND} state_e;

endpackage

// File: rtl/fpu_round.sv
// Rounds a normalised {sign, exp, 24-bit significand, guard/round/sticky} to a packed
// single-precision value and reports exponent overflow.
module fpu_round
  import fpu_pkg::*;
(
  input  logic               sign_i,
  input  logic signed [9:0]  exp_i,
  input  logic [23:0]        sig_i,
  input  logic [2:0]         grs_i,
  input  rnd_e               mode_i,
  output logic [31:0]        y_o,
  output logic               ovf_o
);

  logic              inc;
  logic              away;
  logic [24:0]       sum;
  logic signed [9:0] exp_r;
  logic [22:0]       frac;

  always_comb begin
    case (mode_i)
      RNE:     inc = grs_i[2] & (grs_i[1] | grs_i[0] | sig_i[0]);
      RTZ:     inc = 1'b0;
      RUP:     inc = ~sign_i & (|grs_i);
      default: inc = sign_i & (|grs_i);
    endcase
    sum   = {1'b0, sig_i} + 25'(inc);
    // A carry out of the significand can only leave 1.000..., so shifting right is exact.
    exp_r = exp_i + $signed({9'd0, sum[24]});
    frac  = sum[24] ? sum[23:1] : sum[22:0];
    away  = (mode_i == RNE) | ((mode_i == RUP) & ~sign_i) | ((mode_i == RDN) & sign_i);
    ovf_o = (exp_r > 10'sd254);
    if (ovf_o) begin
      y_o = away ? (POS_INF | {sign_i, 31'd0}) : {sign_i, 8'hFE, 23'h7FFFFF};
    end else begin
      y_o = {sign_i, exp_r[7:0], frac};
    end
  end

endmodule

// File: rtl/fpu_unit.sv
// Multicycle IEEE-754 single-precision add/sub/mul/div unit, start-pulse driven.
// Define FPU_DIV_EN to build the divider; otherwise Sel=11 returns QNAN with Error.
module fpu_unit
  import fpu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  Sel,
  input  logic [1:0]  round,
  input  logic        start,
  output logic        Error,
  output logic        Overflow,
  output logic [31:0] Y
);

  localparam logic signed [9:0] BIAS10 = 10'(BIAS);

  state_e            state_q;
  logic [31:0]       a_q, b_q;
  op_e               op_q;
  rnd_e              rnd_q;
  logic              spec_q, spec_d, spec_err_q, spec_err_d;
  logic [31:0]       spec_y_q, spec_y_d;
  logic [27:0]       s_q, s_d;
  logic signed [9:0] e_q, e_d;
  logic              sgn_q, sgn_d, zsgn_q, zsgn_d;
  logic [23:0]       nsig_q, nsig_d;
  logic [2:0]        ngrs_q, ngrs_d;
  logic signed [9:0] nexp_q, nexp_d;
  logic              nsign_q, nsign_d, nzero_q, nzero_d;

  // Unpacked operands; denormals are flushed to signed zero.
  logic [EXP_W-1:0] ea, eb;
  logic [23:0]      ma, mb;
  logic             sa, sb, sbe, sx, za, zb, ia, ib, na, nb;

  assign sa  = a_q[31];
  assign sb  = b_q[31];
  assign sbe = sb ^ (op_q == SUB);
  assign sx  = sa ^ sb;
  assign ea  = a_q[FRAC_W +: EXP_W];
  assign eb  = b_q[FRAC_W +: EXP_W];
  assign za  = (ea == '0);
  assign zb  = (eb == '0);
  assign ia  = (ea == '1) & (a_q[FRAC_W-1:0] == '0);
  assign ib  = (eb == '1) & (b_q[FRAC_W-1:0] == '0);
  assign na  = (ea == '1) & (a_q[FRAC_W-1:0] != '0);
  assign nb  = (eb == '1) & (b_q[FRAC_W-1:0] != '0);
  assign ma  = za ? 24'd0 : {1'b1, a_q[FRAC_W-1:0]};
  assign mb  = zb ? 24'd0 : {1'b1, b_q[FRAC_W-1:0]};

  always_comb begin
    spec_d     = 1'b1;
    spec_err_d = 1'b0;
    spec_y_d   = QNAN;
    if (na | nb) begin
      spec_err_d = 1'b1;
    end else begin
      case (op_q)
        ADD, SUB: begin
          if (ia & ib & (sa != sbe)) spec_err_d = 1'b1;
          else if (ia)               spec_y_d = POS_INF | {sa, 31'd0};
          else if (ib)               spec_y_d = POS_INF | {sbe, 31'd0};
          else                       spec_d = 1'b0;
        end
        MUL: begin
          if ((ia & zb) | (za & ib)) spec_err_d = 1'b1;
          else if (ia | ib)          spec_y_d = POS_INF | {sx, 31'd0};
          else if (za | zb)          spec_y_d = {sx, 31'd0};
          else                       spec_d = 1'b0;
        end
        default: begin
`ifdef FPU_DIV_EN
          if ((za & zb) | (ia & ib)) spec_err_d = 1'b1;
          else if (ia)               spec_y_d = POS_INF | {sx, 31'd0};
          else if (zb) begin
            spec_y_d   = POS_INF | {sx, 31'd0};
            spec_err_d = 1'b1;
          end
          else if (za | ib)          spec_y_d = {sx, 31'd0};
          else                       spec_d = 1'b0;
`else
          spec_err_d = 1'b1;
`endif
        end
      endcase
    end
  end

`ifdef FPU_DIV_EN
  // Pre-scale the dividend so the quotient always lands in [1,2) with its MSB at bit 27.
  logic        lt;
  logic [51:0] dvd, dvs;
  logic [27:0] q;
  logic [23:0] rem;

  always_comb begin
    lt  = (ma < mb);
    dvd = lt ? {ma, 28'd0} : {1'b0, ma, 27'd0};
    dvs = {28'd0, (mb == 24'd0) ? 24'd1 : mb};
    q   = 28'(dvd / dvs);
    rem = 24'(dvd % dvs);
  end
`endif

  // Common intermediate: s_d bit 26 carries weight 1.0, bit 27 is the carry, bit 0 is sticky.
  logic             a_big;
  logic [7:0]       e_big, e_sml, d;
  logic [23:0]      m_big, m_sml;
  logic [52:0]      sh;
  logic [26:0]      al;
  logic [47:0]      p;

  always_comb begin
    a_big  = ({ea, ma} >= {eb, mb});
    e_big  = a_big ? ea : eb;
    e_sml  = a_big ? eb : ea;
    m_big  = a_big ? ma : mb;
    m_sml  = a_big ? mb : ma;
    d      = e_big - e_sml;
    sh     = {m_sml, 29'd0} >> d;
    al     = (d > 8'd26) ? {26'd0, |m_sml} : {sh[52:27], sh[26] | (|sh[25:0])};
    p      = ma * mb;
    s_d    = '0;
    e_d    = '0;
    sgn_d  = sx;
    zsgn_d = 1'b0;
    case (op_q)
      ADD, SUB: begin
        s_d    = (sa ^ sbe) ? ({1'b0, m_big, 3'd0} - {1'b0, al})
                            : ({1'b0, m_big, 3'd0} + {1'b0, al});
        e_d    = $signed({2'b0, e_big});
        sgn_d  = a_big ? sa : sbe;
        zsgn_d = (sa == sbe) ? sa : (rnd_q == RDN);
      end
      MUL: begin
        s_d = {p[47:21], p[20] | (|p[19:0])};
        e_d = $signed({2'b0, ea}) + $signed({2'b0, eb}) - BIAS10;
      end
      default: begin
`ifdef FPU_DIV_EN
        s_d = {1'b0, q[27:1], q[0] | (|rem)};
        e_d = $signed({2'b0, ea}) - $signed({2'b0, eb}) + BIAS10 - $signed({9'd0, lt});
`endif
      end
    endcase
  end

  logic [4:0]  lz;
  logic [26:0] t;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (s_q[i]) lz = 5'(26 - i);
    end
    t = s_q[26:0] << lz;
    if (s_q[27]) begin
      nsig_d = s_q[27:4];
      ngrs_d = {s_q[3], s_q[2], |s_q[1:0]};
      nexp_d = e_q + 10'sd1;
    end else begin
      nsig_d = t[26:3];
      ngrs_d = t[2:0];
      nexp_d = e_q - $signed({5'd0, lz});
    end
    nzero_d = (s_q == 28'd0) | (nexp_d <= 10'sd0);
    nsign_d = (s_q == 28'd0) ? zsgn_q : sgn_q;
  end

  logic [31:0] rnd_y;
  logic        rnd_ovf;

  fpu_round u_round (
    .sign_i (nsign_q),
    .exp_i  (nexp_q),
    .sig_i  (nsig_q),
    .grs_i  (ngrs_q),
    .mode_i (rnd_q),
    .y_o    (rnd_y),
    .ovf_o  (rnd_ovf)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      Y        <= 32'd0;
      Error    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op_e'(Sel);
            rnd_q   <= rnd_e'(round);
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          spec_q     <= spec_d;
          spec_err_q <= spec_err_d;
          spec_y_q   <= spec_y_d;
          state_q    <= CALC;
        end
        CALC: begin
          s_q     <= s_d;
          e_q     <= e_d;
          sgn_q   <= sgn_d;
          zsgn_q  <= zsgn_d;
          state_q <= NORM;
        end
        NORM: begin
          nsig_q  <= nsig_d;
          ngrs_q  <= ngrs_d;
          nexp_q  <= nexp_d;
          nsign_q <= nsign_d;
          nzero_q <= nzero_d;
          state_q <= ROUND;
        end
        ROUND: begin
          Y        <= spec_q ? spec_y_q : (nzero_q ? {nsign_q, 31'd0} : rnd_y);
          Error    <= spec_q & spec_err_q;
          Overflow <= ~spec_q & ~nzero_q & rnd_ovf;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_unit.sv
// Directed bench for fpu_unit: hand-computed vectors, latency/hold checks, busy start and mid-op reset.
module tb_fpu_unit;

  localparam logic [31:0] QN = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [1:0]  Sel = '0;
  logic [1:0]  round = '0;
  logic        Error, Overflow;
  logic [31:0] Y;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_y   = '0;
  logic        exp_err = 1'b0;
  logic        exp_ovf = 1'b0;

  fpu_unit dut (
    .Clock    (clk),
    .Reset    (Reset),
    .A        (A),
    .B        (B),
    .Sel      (Sel),
    .round    (round),
    .start    (start),
    .Error    (Error),
    .Overflow (Overflow),
    .Y        (Y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, ".Y"}, Y, exp_y);
    check({tag, ".Error"}, {31'd0, Error}, {31'd0, exp_err});
    check({tag, ".Overflow"}, {31'd0, Overflow}, {31'd0, exp_ovf});
  endtask

  // Outputs must still hold the previous result 3 cycles after the start edge
  // and show the new one after the 4th.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] sel, input logic [1:0] rnd,
                       input logic [31:0] ey, input logic ee, input logic eo, input bit poke);
    @(negedge clk);
    A = a; B = b; Sel = sel; round = rnd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom;
    Sel = 2'($urandom_range(0, 3)); round = 2'($urandom_range(0, 3));
    @(posedge clk);
    @(negedge clk);
    if (poke) start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_out({tag, "_hold"});
    @(posedge clk);
    #1;
    exp_y = ey; exp_err = ee; exp_ovf = eo;
    check_out(tag);
  endtask

  initial begin
    Reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out("reset");
    Reset = 1'b0;

    do_op("add", 32'h43700000, 32'h42F00000, 2'b00, 2'b00, 32'h43B40000, 1'b0, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check_out("busy_start_ignored");

    do_op("sub", 32'h43700000, 32'h42F00000, 2'b01, 2'b00, 32'h42F00000, 1'b0, 1'b0, 1'b0);
    do_op("sub_neg", 32'h42F00000, 32'h43700000, 2'b01, 2'b00, 32'hC2F00000, 1'b0, 1'b0, 1'b0);
    do_op("mul", 32'hC3700000, 32'hC2F00000, 2'b10, 2'b00, 32'h46E10000, 1'b0, 1'b0, 1'b0);
`ifdef FPU_DIV_EN
    do_op("div", 32'h43700000, 32'hC2F00000, 2'b11, 2'b00, 32'hC0000000, 1'b0, 1'b0, 1'b0);
    do_op("div_third_rne", 32'h3F800000, 32'h40400000, 2'b11, 2'b00, 32'h3EAAAAAB, 1'b0, 1'b0, 1'b0);
    do_op("div_third_rtz", 32'h3F800000, 32'h40400000, 2'b11, 2'b01, 32'h3EAAAAAA, 1'b0, 1'b0, 1'b0);
    do_op("div_by_zero", 32'h3F800000, 32'h00000000, 2'b11, 2'b00, 32'h7F800000, 1'b1, 1'b0, 1'b0);
`else
    do_op("div", 32'h43700000, 32'hC2F00000, 2'b11, 2'b00, QN, 1'b1, 1'b0, 1'b0);
    do_op("div_by_zero", 32'h3F800000, 32'h00000000, 2'b11, 2'b00, QN, 1'b1, 1'b0, 1'b0);
`endif
    do_op("ovf_rne", 32'h7F010000, 32'h7F010000, 2'b00, 2'b00, 32'h7F800000, 1'b0, 1'b1, 1'b0);
    do_op("ovf_rtz", 32'h7F010000, 32'h7F010000, 2'b00, 2'b01, 32'h7F7FFFFF, 1'b0, 1'b1, 1'b0);
    do_op("ovf_rup", 32'h7F010000, 32'h7F010000, 2'b00, 2'b10, 32'h7F800000, 1'b0, 1'b1, 1'b0);
    do_op("ovf_rdn", 32'h7F010000, 32'h7F010000, 2'b00, 2'b11, 32'h7F7FFFFF, 1'b0, 1'b1, 1'b0);
    do_op("ovf_neg_rup", 32'hFF010000, 32'hFF010000, 2'b00, 2'b10, 32'hFF7FFFFF, 1'b0, 1'b1, 1'b0);
    do_op("ovf_neg_rdn", 32'hFF010000, 32'hFF010000, 2'b00, 2'b11, 32'hFF800000, 1'b0, 1'b1, 1'b0);
    do_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 2'b00, 2'b00, QN, 1'b1, 1'b0, 1'b0);
    do_op("zero_div_zero", 32'h00000000, 32'h00000000, 2'b11, 2'b00, QN, 1'b1, 1'b0, 1'b0);
    do_op("cancel_rne", 32'h7F010000, 32'h7F010000, 2'b01, 2'b00, 32'h00000000, 1'b0, 1'b0, 1'b0);
    do_op("cancel_rdn", 32'h7F010000, 32'h7F010000, 2'b01, 2'b11, 32'h80000000, 1'b0, 1'b0, 1'b0);
    do_op("tie_rne", 32'h3F800000, 32'h33800000, 2'b00, 2'b00, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    do_op("tie_rup", 32'h3F800000, 32'h33800000, 2'b00, 2'b10, 32'h3F800001, 1'b0, 1'b0, 1'b0);
    do_op("underflow_mul", 32'h00800000, 32'h00800000, 2'b10, 2'b00, 32'h00000000, 1'b0, 1'b0, 1'b0);
    do_op("denorm_in", 32'h00400000, 32'h3F800000, 2'b00, 2'b00, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    do_op("inf_plus_one", 32'h7F800000, 32'h3F800000, 2'b00, 2'b00, 32'h7F800000, 1'b0, 1'b0, 1'b0);
    do_op("zero_mul_neg", 32'h00000000, 32'hC0000000, 2'b10, 2'b00, 32'h80000000, 1'b0, 1'b0, 1'b0);
    do_op("zero_mul_inf", 32'h00000000, 32'h7F800000, 2'b10, 2'b00, QN, 1'b1, 1'b0, 1'b0);
    do_op("nan_in", 32'h7FC00001, 32'h3F800000, 2'b00, 2'b00, QN, 1'b1, 1'b0, 1'b0);

    // Reset two cycles into a multiply: outputs clear and no result appears later.
    @(negedge clk);
    A = 32'h43700000; B = 32'h42F00000; Sel = 2'b10; round = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    exp_y = '0; exp_err = 1'b0; exp_ovf = 1'b0;
    check_out("mid_reset");
    repeat (6) @(posedge clk);
    #1;
    check_out("aborted");
    do_op("after_reset", 32'h43700000, 32'h42F00000, 2'b00, 2'b00, 32'h43B40000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
